// File: rtl/layer_stream_loader_pkg.sv
// Shared types for the layer stream loader: FSM states, descriptor record
// and index-width helper.
package layer_stream_loader_pkg;

    localparam int unsigned DESC_ADDR_W    = 24;
    localparam int unsigned DEF_NUM_LAYERS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RECV,
        ST_DRAIN,
        ST_DONE
    } lsl_state_t;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] addr;
        logic [DESC_ADDR_W-1:0] len;
    } lsl_desc_t;

    // Index width that stays at least one bit wide for single-entry tables.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_width(DEF_NUM_LAYERS);

endpackage

// File: rtl/layer_stream_loader_fifo.sv
// Synchronous word FIFO with registered pointers and a combinational head.
module sync_word_fifo #(
    parameter int unsigned WIDTH = 257,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/layer_stream_loader.sv
// Loads one layer from flash: issues a read request, packs received bytes
// MSB-first into OUT_W words and streams them out through a small FIFO.
module layer_stream_loader
    import layer_stream_loader_pkg::*;
#(
    parameter int unsigned OUT_W      = 256,
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned ADDR_W     = DESC_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic                             cfg_we,
    input  logic [idx_width(NUM_LAYERS)-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]                cfg_addr,
    input  logic [ADDR_W-1:0]                cfg_len,
    input  logic                             layer_load_start,
    input  logic [idx_width(NUM_LAYERS)-1:0] layer_id,
    output logic                             rd_start,
    output logic [ADDR_W-1:0]                rd_addr,
    output logic [ADDR_W-1:0]                rd_len,
    input  logic                             rx_flag,
    input  logic [7:0]                       rx_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_data,
    output logic                             out_last,
    output logic                             busy,
    output logic                             layer_load_finish,
    output logic                             overflow
);

    localparam int unsigned BPW    = OUT_W / 8;
    localparam int unsigned BIDX_W = idx_width(BPW);

    lsl_state_t        r_state;
    lsl_desc_t         r_table [NUM_LAYERS];
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_rd_len;
    logic [ADDR_W-1:0] r_cnt;
    logic [OUT_W-1:0]  r_pack;
    logic [BIDX_W-1:0] r_bidx;
    logic              r_rd_start;
    logic              r_busy;
    logic              r_finish;
    logic              r_overflow;

    logic [ADDR_W-1:0] w_cnt_next;
    logic [OUT_W-1:0]  w_word;
    logic              w_rx_take;
    logic              w_word_full;
    logic              w_last_byte;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [OUT_W:0]    w_fifo_out;

    always_comb begin
        w_rx_take   = (r_state == ST_RECV) && rx_flag;
        w_cnt_next  = r_cnt + 1'b1;
        w_last_byte = w_rx_take && (w_cnt_next == r_rd_len);
        w_word_full = (r_bidx == BIDX_W'(BPW - 1));
        w_push      = w_last_byte || (w_rx_take && w_word_full);
        w_word      = r_pack | ({rx_data, {(OUT_W-8){1'b0}}} >> {r_bidx, 3'b000});
        w_pop       = !w_fifo_empty && out_ready;
        w_drop      = w_push && w_fifo_full && !w_pop;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_rd_addr  <= '0;
            r_rd_len   <= '0;
            r_cnt      <= '0;
            r_pack     <= '0;
            r_bidx     <= '0;
            r_rd_start <= 1'b0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_overflow <= 1'b0;
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_rd_start <= 1'b0;
            r_finish   <= 1'b0;
            if (cfg_we) begin
                r_table[cfg_idx] <= '{addr: cfg_addr, len: cfg_len};
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // Packer restarts empty after every push, so padding bytes stay zero.
            if (w_rx_take) begin
                r_cnt <= w_cnt_next;
                if (w_push) begin
                    r_pack <= '0;
                    r_bidx <= '0;
                end else begin
                    r_pack <= w_word;
                    r_bidx <= r_bidx + 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (layer_load_start) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        r_pack <= '0;
                        r_bidx <= '0;
                        if (r_table[layer_id].len == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state    <= ST_REQ;
                            r_rd_start <= 1'b1;
                            r_rd_addr  <= r_table[layer_id].addr;
                            r_rd_len   <= r_table[layer_id].len;
                        end
                    end
                end
                ST_REQ: begin
                    r_state <= ST_RECV;
                end
                ST_RECV: begin
                    if (w_last_byte) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_fifo_empty) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_finish <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    sync_word_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_push  (w_push && !w_drop),
        .i_data  ({w_last_byte, w_word}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign rd_start          = r_rd_start;
    assign rd_addr           = r_rd_addr;
    assign rd_len            = r_rd_len;
    assign busy              = r_busy;
    assign layer_load_finish = r_finish;
    assign overflow          = r_overflow;
    assign out_valid         = !w_fifo_empty;
    assign out_data          = w_fifo_empty ? '0 : w_fifo_out[OUT_W-1:0];
    assign out_last          = !w_fifo_empty && w_fifo_out[OUT_W];

endmodule
